// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: opcodes, ALU sub-ops, instruction
// class indices and the decoded-instruction bundle.
package decode_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLL = 5'd4;
    localparam logic [4:0] ALU_SRA = 5'd5;
    localparam logic [4:0] ALU_MUL = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;

    localparam int unsigned NUM_CLASSES = 18;

    // Bit positions within the one-hot instruction class vector.
    typedef enum logic [4:0] {
        IS_ADD, IS_ADDI, IS_SUB, IS_AND, IS_OR, IS_SLL, IS_SRA, IS_MUL, IS_DIV,
        IS_SW, IS_LW, IS_J, IS_BNE, IS_BLT, IS_JAL, IS_JR, IS_BEX, IS_SETX
    } is_idx_e;

    typedef struct packed {
        logic [4:0]             opcode;
        logic [4:0]             rd;
        logic [4:0]             rs;
        logic [4:0]             rt;
        logic [4:0]             shamt;
        logic [4:0]             alu_op;
        logic [31:0]            imm;
        logic [26:0]            target;
        logic [NUM_CLASSES-1:0] is;
        logic [4:0]             reg_a;
        logic [4:0]             reg_b;
        logic                   use_a;
        logic                   use_b;
    } decoded_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction decode: field extraction, one-hot class,
// register read-address selection and operand-use flags.
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int BEX_REG = 30
) (
    input  logic [31:0] instr,
    output decoded_t    dec
);

    always_comb begin
        dec        = '0;
        dec.opcode = instr[31:27];
        dec.rd     = instr[26:22];
        dec.rs     = instr[21:17];
        dec.rt     = instr[16:12];
        dec.shamt  = instr[11:7];
        dec.alu_op = instr[6:2];
        dec.imm    = {{15{instr[16]}}, instr[16:0]};
        dec.target = instr[26:0];
        dec.reg_a  = instr[21:17];
        dec.reg_b  = instr[16:12];

        case (instr[31:27])
            OP_R: begin
                dec.use_a = 1'b1;
                dec.use_b = 1'b1;
                case (instr[6:2])
                    ALU_ADD: dec.is[IS_ADD] = 1'b1;
                    ALU_SUB: dec.is[IS_SUB] = 1'b1;
                    ALU_AND: dec.is[IS_AND] = 1'b1;
                    ALU_OR:  dec.is[IS_OR]  = 1'b1;
                    ALU_SLL: dec.is[IS_SLL] = 1'b1;
                    ALU_SRA: dec.is[IS_SRA] = 1'b1;
                    ALU_MUL: dec.is[IS_MUL] = 1'b1;
                    ALU_DIV: dec.is[IS_DIV] = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec.is[IS_ADDI] = 1'b1;
                dec.use_a       = 1'b1;
            end
            OP_LW: begin
                dec.is[IS_LW] = 1'b1;
                dec.use_a     = 1'b1;
            end
            OP_SW: begin
                dec.is[IS_SW] = 1'b1;
                dec.use_a     = 1'b1;
                dec.use_b     = 1'b1;
                dec.reg_b     = instr[26:22];
            end
            OP_BNE, OP_BLT: begin
                dec.is[IS_BNE] = (instr[31:27] == OP_BNE);
                dec.is[IS_BLT] = (instr[31:27] == OP_BLT);
                dec.use_a      = 1'b1;
                dec.use_b      = 1'b1;
                dec.reg_a      = instr[26:22];
                dec.reg_b      = instr[21:17];
            end
            OP_JR: begin
                dec.is[IS_JR] = 1'b1;
                dec.use_a     = 1'b1;
                dec.reg_a     = instr[26:22];
            end
            OP_BEX: begin
                dec.is[IS_BEX] = 1'b1;
                dec.use_a      = 1'b1;
                dec.reg_a      = 5'(BEX_REG);
            end
            OP_J:    dec.is[IS_J]    = 1'b1;
            OP_JAL:  dec.is[IS_JAL]  = 1'b1;
            OP_SETX: dec.is[IS_SETX] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: register-file addressing, writeback bypass, load-use
// interlock and the D/X pipeline register with its stall counter.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter  int IADDR_W = 12,
    parameter  int DATA_W  = 32,
    parameter  int NREG    = 32,
    parameter  int BEX_REG = 30,
    parameter  int CNT_W   = 16,
    localparam int REG_W   = $clog2(NREG)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fd_valid,
    input  logic [31:0]        fd_instr,
    input  logic [IADDR_W-1:0] fd_pc,
    output logic               fd_ready,
    input  logic               flush,
    output logic [REG_W-1:0]   ctrl_readRegA,
    output logic [REG_W-1:0]   ctrl_readRegB,
    input  logic [DATA_W-1:0]  data_readRegA,
    input  logic [DATA_W-1:0]  data_readRegB,
    input  logic               wb_we,
    input  logic [REG_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               x_ready,
    output logic               dx_valid,
    output logic [4:0]         dx_opcode,
    output logic [4:0]         dx_rd,
    output logic [4:0]         dx_rs,
    output logic [4:0]         dx_rt,
    output logic [4:0]         dx_shamt,
    output logic [4:0]         dx_alu_op,
    output logic [31:0]        dx_imm,
    output logic [26:0]        dx_target,
    output logic [DATA_W-1:0]  dx_opA,
    output logic [DATA_W-1:0]  dx_opB,
    output logic [IADDR_W-1:0] dx_pc,
    output logic [NUM_CLASSES-1:0] dx_is,
    output logic [CNT_W-1:0]   stall_count
);

    decoded_t          dec;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              adv;
    logic              hazard;
    logic              load_instr;
    logic              count_stall;

    decode_ctrl #(.BEX_REG(BEX_REG)) u_ctrl (
        .instr (fd_instr),
        .dec   (dec)
    );

    always_comb begin
        ctrl_readRegA = REG_W'(dec.reg_a);
        ctrl_readRegB = REG_W'(dec.reg_b);
    end

    always_comb begin
        op_a = data_readRegA;
        if (dec.reg_a == '0)
            op_a = '0;
        else if (wb_we && (wb_addr == ctrl_readRegA))
            op_a = wb_data;

        op_b = data_readRegB;
        if (dec.reg_b == '0)
            op_b = '0;
        else if (wb_we && (wb_addr == ctrl_readRegB))
            op_b = wb_data;
    end

    // Only a live load in D/X can hazard; its data is not ready until after execute.
    always_comb begin
        adv    = ~dx_valid | x_ready;
        hazard = fd_valid && dx_valid && dx_is[IS_LW] && (dx_rd != '0) &&
                 ((dec.use_a && (dec.reg_a == dx_rd)) ||
                  (dec.use_b && (dec.reg_b == dx_rd)));
        fd_ready    = flush | (adv & ~hazard);
        load_instr  = ~flush & adv & ~hazard & fd_valid & (fd_instr != '0);
        count_stall = ~flush & adv & hazard;
    end

    always_ff @(posedge clock) begin
        if (reset || flush || (adv && !load_instr)) begin
            dx_valid  <= 1'b0;
            dx_opcode <= '0;
            dx_rd     <= '0;
            dx_rs     <= '0;
            dx_rt     <= '0;
            dx_shamt  <= '0;
            dx_alu_op <= '0;
            dx_imm    <= '0;
            dx_target <= '0;
            dx_opA    <= '0;
            dx_opB    <= '0;
            dx_pc     <= '0;
            dx_is     <= '0;
        end else if (load_instr) begin
            dx_valid  <= 1'b1;
            dx_opcode <= dec.opcode;
            dx_rd     <= dec.rd;
            dx_rs     <= dec.rs;
            dx_rt     <= dec.rt;
            dx_shamt  <= dec.shamt;
            dx_alu_op <= dec.alu_op;
            dx_imm    <= dec.imm;
            dx_target <= dec.target;
            dx_opA    <= op_a;
            dx_opB    <= op_b;
            dx_pc     <= fd_pc;
            dx_is     <= dec.is;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            stall_count <= '0;
        else if (count_stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed and randomized checks of decode_stage_pipe against a
// cycle-level reference model of the decode/interlock rules.
module tb_decode_stage_pipe;

    localparam int IADDR_W = 12;
    localparam int DATA_W  = 32;
    localparam int NREG    = 32;
    localparam int REG_W   = 5;
    localparam int BEX_REG = 30;
    localparam int CNT_W   = 3;

    localparam int C_ADD = 0, C_ADDI = 1, C_SUB = 2, C_AND = 3, C_OR = 4,
                   C_SLL = 5, C_SRA = 6, C_MUL = 7, C_DIV = 8, C_SW = 9,
                   C_LW = 10, C_J = 11, C_BNE = 12, C_BLT = 13, C_JAL = 14,
                   C_JR = 15, C_BEX = 16, C_SETX = 17;

    logic               clock = 1'b0;
    logic               reset;
    logic               fd_valid;
    logic [31:0]        fd_instr;
    logic [IADDR_W-1:0] fd_pc;
    logic               fd_ready;
    logic               flush;
    logic [REG_W-1:0]   ctrl_readRegA, ctrl_readRegB;
    logic [DATA_W-1:0]  data_readRegA, data_readRegB;
    logic               wb_we;
    logic [REG_W-1:0]   wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               x_ready;
    logic               dx_valid;
    logic [4:0]         dx_opcode, dx_rd, dx_rs, dx_rt, dx_shamt, dx_alu_op;
    logic [31:0]        dx_imm;
    logic [26:0]        dx_target;
    logic [DATA_W-1:0]  dx_opA, dx_opB;
    logic [IADDR_W-1:0] dx_pc;
    logic [17:0]        dx_is;
    logic [CNT_W-1:0]   stall_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    decode_stage_pipe #(
        .IADDR_W (IADDR_W),
        .DATA_W  (DATA_W),
        .NREG    (NREG),
        .BEX_REG (BEX_REG),
        .CNT_W   (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fd_valid      (fd_valid),
        .fd_instr      (fd_instr),
        .fd_pc         (fd_pc),
        .fd_ready      (fd_ready),
        .flush         (flush),
        .ctrl_readRegA (ctrl_readRegA),
        .ctrl_readRegB (ctrl_readRegB),
        .data_readRegA (data_readRegA),
        .data_readRegB (data_readRegB),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .x_ready       (x_ready),
        .dx_valid      (dx_valid),
        .dx_opcode     (dx_opcode),
        .dx_rd         (dx_rd),
        .dx_rs         (dx_rs),
        .dx_rt         (dx_rt),
        .dx_shamt      (dx_shamt),
        .dx_alu_op     (dx_alu_op),
        .dx_imm        (dx_imm),
        .dx_target     (dx_target),
        .dx_opA        (dx_opA),
        .dx_opB        (dx_opB),
        .dx_pc         (dx_pc),
        .dx_is         (dx_is),
        .stall_count   (stall_count)
    );

    typedef struct {
        bit        valid;
        bit [4:0]  op, rd, rs, rt, sh, alu;
        bit [31:0] imm;
        bit [26:0] tgt;
        bit [31:0] a, b;
        bit [11:0] pc;
        bit [17:0] is;
    } dx_t;

    dx_t         m;
    int unsigned m_stall;
    logic        seen_ready;
    logic [4:0]  seen_ra, seen_rb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] rtype(input int alu, input int rd, input int rs, input int rt);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'd0};
    endfunction

    function automatic bit [31:0] itype(input int op, input int rd, input int rs, input int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction

    // Class index, operand use and read addresses from the instruction set rules.
    function automatic void classify(input bit [31:0] ins, output int cls,
                                     output bit ua, output bit ub,
                                     output bit [4:0] ra, output bit [4:0] rb);
        int op, alu;
        op  = int'(ins[31:27]);
        alu = int'(ins[6:2]);
        cls = -1; ua = 0; ub = 0;
        ra  = ins[21:17];
        rb  = ins[16:12];
        case (op)
            0: begin
                int r_cls[8];
                r_cls = '{C_ADD, C_SUB, C_AND, C_OR, C_SLL, C_SRA, C_MUL, C_DIV};
                ua = 1; ub = 1;
                if (alu < 8) cls = r_cls[alu];
            end
            5:  begin cls = C_ADDI; ua = 1; end
            8:  begin cls = C_LW;   ua = 1; end
            7:  begin cls = C_SW;   ua = 1; ub = 1; rb = ins[26:22]; end
            2:  begin cls = C_BNE;  ua = 1; ub = 1; ra = ins[26:22]; rb = ins[21:17]; end
            6:  begin cls = C_BLT;  ua = 1; ub = 1; ra = ins[26:22]; rb = ins[21:17]; end
            4:  begin cls = C_JR;   ua = 1; ra = ins[26:22]; end
            22: begin cls = C_BEX;  ua = 1; ra = 5'(BEX_REG); end
            1:  cls = C_J;
            3:  cls = C_JAL;
            21: cls = C_SETX;
            default: ;
        endcase
    endfunction

    function automatic bit [31:0] operand(input bit [4:0] addr, input bit [31:0] rf);
        if (addr == 0) return 0;
        if (wb_we && wb_addr == addr) return wb_data;
        return rf;
    endfunction

    // One clock: check combinational outputs, advance model, check D/X.
    task automatic step();
        dx_t         nx;
        int unsigned nstall;
        int          cls;
        bit          ua, ub, adv, haz, exp_ready;
        bit [4:0]    ra, rb;
        #1;
        classify(fd_instr, cls, ua, ub, ra, rb);
        adv = !m.valid || x_ready;
        haz = fd_valid && m.valid && m.is[C_LW] && m.rd != 0 &&
              ((ua && ra == m.rd) || (ub && rb == m.rd));
        exp_ready  = flush || (adv && !haz);
        seen_ready = fd_ready;
        seen_ra    = ctrl_readRegA;
        seen_rb    = ctrl_readRegB;
        if (!reset) begin
            chk("fd_ready", 32'(fd_ready), 32'(exp_ready));
            chk("readRegA", 32'(ctrl_readRegA), 32'(ra));
            chk("readRegB", 32'(ctrl_readRegB), 32'(rb));
        end
        nx = m;
        nstall = m_stall;
        if (reset) begin
            nx = '{default: 0};
            nstall = 0;
        end else if (flush) begin
            nx.valid = 0;
        end else if (!adv) begin
        end else if (haz) begin
            nx.valid = 0;
            if (nstall < (1 << CNT_W) - 1) nstall++;
        end else if (fd_valid && fd_instr != 0) begin
            nx.valid = 1;
            nx.op  = fd_instr[31:27];
            nx.rd  = fd_instr[26:22];
            nx.rs  = fd_instr[21:17];
            nx.rt  = fd_instr[16:12];
            nx.sh  = fd_instr[11:7];
            nx.alu = fd_instr[6:2];
            nx.imm = fd_instr[16] ? {15'h7fff, fd_instr[16:0]} : {15'h0, fd_instr[16:0]};
            nx.tgt = fd_instr[26:0];
            nx.is  = (cls < 0) ? 18'd0 : (18'd1 << cls);
            nx.a   = operand(ra, data_readRegA);
            nx.b   = operand(rb, data_readRegB);
            nx.pc  = fd_pc;
        end else begin
            nx.valid = 0;
        end
        @(posedge clock);
        #1;
        m = nx;
        m_stall = nstall;
        chk("dx_valid", 32'(dx_valid), 32'(m.valid));
        chk("stall_count", 32'(stall_count), m_stall);
        if (m.valid) begin
            chk("dx_opcode", 32'(dx_opcode), 32'(m.op));
            chk("dx_rd", 32'(dx_rd), 32'(m.rd));
            chk("dx_rs", 32'(dx_rs), 32'(m.rs));
            chk("dx_rt", 32'(dx_rt), 32'(m.rt));
            chk("dx_shamt", 32'(dx_shamt), 32'(m.sh));
            chk("dx_alu_op", 32'(dx_alu_op), 32'(m.alu));
            chk("dx_imm", dx_imm, m.imm);
            chk("dx_target", 32'(dx_target), 32'(m.tgt));
            chk("dx_is", 32'(dx_is), 32'(m.is));
            chk("dx_opA", dx_opA, m.a);
            chk("dx_opB", dx_opB, m.b);
            chk("dx_pc", 32'(dx_pc), 32'(m.pc));
        end
        @(negedge clock);
    endtask

    function automatic bit [31:0] rand_instr();
        bit [31:0] ins;
        int ops[15];
        int op;
        ops = '{0, 0, 0, 5, 8, 8, 7, 2, 6, 4, 22, 1, 3, 21, 31};
        if ($urandom_range(0, 15) == 0) return 0;
        op  = ops[$urandom_range(0, 14)];
        ins = $urandom;
        ins[31:27] = 5'(op);
        ins[26:22] = 5'($urandom_range(0, 3));
        ins[21:17] = 5'($urandom_range(0, 3));
        ins[16:12] = 5'($urandom_range(0, 3));
        if (op == 0) ins[6:2] = 5'($urandom_range(0, 9));
        return ins;
    endfunction

    task automatic quiet();
        fd_valid = 0; fd_instr = 0; fd_pc = 12'h0; flush = 0; x_ready = 1;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        data_readRegA = $urandom; data_readRegB = $urandom;
    endtask

    int unsigned stall_before;

    initial begin
        m = '{default: 0};
        m_stall = 0;
        quiet();
        reset = 1;
        @(negedge clock);
        step();
        step();
        reset = 0;
        chk("rst_valid", 32'(dx_valid), 0);
        chk("rst_opcode", 32'(dx_opcode), 0);
        chk("rst_rd", 32'(dx_rd), 0);
        chk("rst_imm", dx_imm, 0);
        chk("rst_target", 32'(dx_target), 0);
        chk("rst_opA", dx_opA, 0);
        chk("rst_opB", dx_opB, 0);
        chk("rst_pc", 32'(dx_pc), 0);
        chk("rst_is", 32'(dx_is), 0);
        chk("rst_stall", 32'(stall_count), 0);

        // lw $5,0($1) followed by add $6,$5,$2
        fd_valid = 1; fd_instr = itype(8, 5, 1, 0); fd_pc = 12'h010;
        step();
        fd_instr = rtype(0, 6, 5, 2); fd_pc = 12'h011;
        step();
        chk("lu_ready", 32'(seen_ready), 0);
        chk("lu_bubble", 32'(dx_valid), 0);
        step();
        chk("lu_issue_valid", 32'(dx_valid), 1);
        chk("lu_issue_rd", 32'(dx_rd), 6);
        chk("lu_stall", 32'(stall_count), 1);

        // writeback bypass on both operands
        wb_we = 1; wb_addr = 3; wb_data = 32'hDEAD;
        data_readRegA = 0; data_readRegB = 0;
        fd_instr = rtype(0, 4, 3, 3);
        step();
        chk("byp_opA", dx_opA, 32'hDEAD);
        chk("byp_opB", dx_opB, 32'hDEAD);
        wb_we = 0;

        fd_instr = itype(2, 7, 8, 5);
        step();
        chk("bne_ra", 32'(seen_ra), 7);
        chk("bne_rb", 32'(seen_rb), 8);
        fd_instr = {5'b10110, 27'd100};
        step();
        chk("bex_ra", 32'(seen_ra), 30);
        fd_instr = itype(7, 9, 2, 4);
        step();
        chk("sw_rb", 32'(seen_rb), 9);

        // execute back-pressure
        fd_instr = rtype(0, 6, 1, 2);
        step();
        x_ready = 0;
        fd_instr = rtype(1, 7, 1, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", 32'(seen_ready), 0);
            chk("bp_hold_rd", 32'(dx_rd), 6);
        end
        x_ready = 1;
        step();
        chk("bp_release_rd", 32'(dx_rd), 7);

        // flush coincident with a load-use hazard
        fd_instr = itype(8, 5, 1, 0);
        step();
        stall_before = 32'(stall_count);
        flush = 1;
        fd_instr = rtype(0, 6, 5, 2);
        step();
        flush = 0;
        chk("fl_ready", 32'(seen_ready), 1);
        chk("fl_valid", 32'(dx_valid), 0);
        chk("fl_stall", 32'(stall_count), stall_before);

        // NOP squash and lw to $0
        fd_instr = 0;
        step();
        chk("nop_ready", 32'(seen_ready), 1);
        chk("nop_valid", 32'(dx_valid), 0);
        fd_instr = itype(8, 0, 1, 0);
        step();
        fd_instr = rtype(0, 6, 0, 0);
        step();
        chk("lw0_ready", 32'(seen_ready), 1);
        chk("lw0_valid", 32'(dx_valid), 1);

        // stall counter saturation
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 9; i++) begin
            fd_instr = itype(8, 5, 1, 0);
            step();
            fd_instr = rtype(0, 6, 5, 2);
            step();
            step();
        end
        chk("sat_stall", 32'(stall_count), 7);

        for (int i = 0; i < 500; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            x_ready  = ($urandom_range(0, 9) < 7);
            fd_valid = ($urandom_range(0, 7) != 0);
            fd_instr = rand_instr();
            fd_pc    = 12'($urandom);
            wb_we    = $urandom_range(0, 1) == 1;
            wb_addr  = 5'($urandom_range(0, 3));
            wb_data  = $urandom;
            data_readRegA = $urandom;
            data_readRegB = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised decode stage with an owned D/X pipeline register, load-use interlock, writeback bypass, NOP squash and flush. Sits between the F/D latch and execute. It decodes the F/D instruction, drives register-file read addresses, bypasses same-cycle writeback data, and registers all decoded fields into D/X under a valid/ready handshake. It stalls fetch for exactly one cycle on a load-use hazard.

## Interface
Parameters:
- IADDR_W, 12, instruction address width
- DATA_W, 32, register data width
- NREG, 32, register count; REG_W = $clog2(NREG)
- BEX_REG, 30, register read by bex
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- fd_valid  in  1  F/D holds an instruction
- fd_instr  in  32  instruction word
- fd_pc  in  IADDR_W  next-PC value carried with the instruction
- fd_ready  out  1  decode consumes F/D this cycle
- flush  in  1  execute redirect; kill D/X and the F/D instruction
- ctrl_readRegA, ctrl_readRegB  out  REG_W  register-file read addresses
- data_readRegA, data_readRegB  in  DATA_W  register-file read data
- wb_we  in  1  writeback enable
- wb_addr  in  REG_W  writeback register
- wb_data  in  DATA_W  writeback data
- x_ready  in  1  execute accepts D/X
- dx_valid  out  1  D/X holds a live instruction
- dx_opcode, dx_rd, dx_rs, dx_rt, dx_shamt, dx_alu_op  out  5 each  registered fields
- dx_imm  out  32  sign-extended imm[16:0]
- dx_target  out  27  instr[26:0]
- dx_opA, dx_opB  out  DATA_W  operands after bypass
- dx_pc  out  IADDR_W  registered fd_pc
- dx_is  out  18  one-hot class: add, addi, sub, and, or, sll, sra, mul, div, sw, lw, j, bne, blt, jal, jr, bex, setx
- stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Read-address select:
  - regA = BEX_REG for bex; rd for bne, blt and jr; otherwise rs.
  - regB = rd for sw; rs for bne and blt; otherwise rt.
- Operand use:
  - R-type uses A and B.
  - addi and lw use A.
  - sw, bne and blt use A and B.
  - jr and bex use A.
  - j, jal and setx use neither.
- Bypass: when wb_we=1, wb_addr equals the read address and the read address is not 0, the operand takes wb_data instead of the register-file data. Register 0 always reads 0.
- Hazard: raised when all of the following hold:
  - dx_valid=1
  - D/X holds lw
  - dx_rd is not 0
  - a used operand address equals dx_rd
- adv = ~dx_valid | x_ready. D/X loads only when adv=1.
- Priority, highest first:
  1. reset: all D/X fields 0, dx_valid=0, stall_count=0.
  2. flush: dx_valid<=0, fd_ready=1, the F/D instruction is discarded.
  3. adv=0: D/X holds, fd_ready=0.
  4. hazard: D/X loads a bubble (dx_valid<=0), fd_ready=0, stall_count increments.
  5. fd_valid=1 and fd_instr=0 (NOP): bubble, fd_ready=1.
  6. fd_valid=1: D/X loads the decoded instruction, dx_valid<=1, fd_ready=1.
  7. fd_valid=0: bubble, fd_ready=1.
- An unknown opcode loads with dx_is=0 and dx_valid=1.
- stall_count saturates at all-ones.

## Timing
- One-cycle latency from F/D acceptance to dx_valid.
- A load-use hazard costs exactly one bubble. On the next cycle D/X holds the bubble, the hazard clears, and the consumer is accepted.
- fd_ready is combinational from fd_instr, D/X state, x_ready and flush. No combinational path exists from x_ready to the ctrl_readReg outputs.
- Reset mid-stall drops the held state. The F/D instruction is re-presented by upstream.
- Flush in the same cycle as a hazard: flush wins, and stall_count does not increment.
- Outputs after reset: every dx_* output is 0, dx_valid=0, stall_count=0.

## Structure
- Shared package decode_pkg holds:
  - opcode constants: R=00000, j=00001, bne=00010, jal=00011, jr=00100, addi=00101, blt=00110, sw=00111, lw=01000, setx=10101, bex=10110
  - alu_op constants for add, sub, and, or, sll, sra, mul, div
  - the dx_is bit-index enum
- One sub-module, decode_ctrl: purely combinational field extraction, class one-hot and operand-use flags.
- The top level holds the hazard logic, bypass, D/X register and counter.

## Test plan
- lw $5,0($1) then add $6,$5,$2 with x_ready=1 -> one cycle with fd_ready=0 and a D/X bubble; add issues the following cycle; stall_count=1.
- wb_we=1, wb_addr=3, wb_data=0xDEAD while decoding add $4,$3,$3 with data_readRegA/B=0 -> dx_opA = dx_opB = 0xDEAD.
- bne $7,$8 -> ctrl_readRegA=7, ctrl_readRegB=8. bex -> ctrl_readRegA=30. sw $9,4($2) -> ctrl_readRegB=9.
- x_ready=0 for 3 cycles with D/X valid -> D/X stable, fd_ready=0; release -> the next instruction loads.
- flush asserted together with a hazard -> dx_valid=0 next cycle, fd_ready=1, stall_count unchanged.
- fd_instr=0 with fd_valid=1 -> dx_valid=0, fd_ready=1. lw $0 followed by a consumer of $0 -> no stall.
